// File: rtl/reduce_sweep_checker.sv
// Clocked exhaustive sweep checker for a reduction AND/OR/XOR block: drives every input
// vector, samples the block's outputs after a settle window and tallies mismatches.
module reduce_sweep_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    output logic [WIDTH-1:0] vec_out_o,
    input  logic             dut_and_i,
    input  logic             dut_or_i,
    input  logic             dut_xor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [WIDTH:0]   err_count_o,
    output logic [WIDTH-1:0] first_fail_vec_o,
    output logic             first_fail_valid_o
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [WIDTH:0]   err_q, err_d;
    logic [WIDTH-1:0] ffv_q, ffv_d;
    logic             ffvalid_q, ffvalid_d;
    logic [2:0]       expected;
    logic             mismatch;

    assign expected = {&vec_q, |vec_q, ^vec_q};
    assign mismatch = (expected != {dut_and_i, dut_or_i, dut_xor_i});

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        hold_d    = hold_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        unique case (state_q)
            StIdle, StDone: begin
                // DONE restarts exactly like IDLE, clearing results on the same edge.
                if (start_i) begin
                    state_d   = StDrive;
                    vec_d     = '0;
                    hold_d    = '0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                end
            end
            StDrive: begin
                if (hold_q == HoldLast) begin
                    state_d = StCheck;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
                end
                if (vec_q == {WIDTH{1'b1}}) begin
                    state_d = StDone;
                end else begin
                    state_d = StDrive;
                    vec_d   = vec_q + 1'b1;
                    hold_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            vec_q     <= '0;
            hold_q    <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    // Status is decoded from registered state only; dut_* never reach an output directly.
    assign vec_out_o          = vec_q;
    assign busy_o             = (state_q == StDrive) || (state_q == StCheck);
    assign done_o             = (state_q == StDone);
    assign pass_o             = (state_q == StDone) && (err_q == '0);
    assign err_count_o        = err_q;
    assign first_fail_vec_o   = ffv_q;
    assign first_fail_valid_o = ffvalid_q;

endmodule

// File: tb/tb_reduce_sweep_checker.sv
// Directed bench: default-size checker driven by a faultable reduction model, plus a
// WIDTH=3 / HOLD_CYCLES=1 instance driven by a golden model.
module tb_reduce_sweep_checker;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic       start_a = 1'b0;
    logic [3:0] vec_a;
    logic       and_a, or_a, xor_a;
    logic       busy_a, done_a, pass_a, ffvalid_a;
    logic [4:0] err_a;
    logic [3:0] ffv_a;
    logic [1:0] mode = 2'd0;  // 0 golden, 1 xor stuck-at-0, 2 and wrong at 4'hF

    assign and_a = (&vec_a) ^ ((mode == 2'd2) && (vec_a == 4'hF));
    assign or_a  = |vec_a;
    assign xor_a = (mode == 2'd1) ? 1'b0 : ^vec_a;

    reduce_sweep_checker #(.WIDTH(4), .HOLD_CYCLES(2)) u_dut_a (
        .clk                (clk),
        .resetn             (resetn),
        .start_i            (start_a),
        .vec_out_o          (vec_a),
        .dut_and_i          (and_a),
        .dut_or_i           (or_a),
        .dut_xor_i          (xor_a),
        .busy_o             (busy_a),
        .done_o             (done_a),
        .pass_o             (pass_a),
        .err_count_o        (err_a),
        .first_fail_vec_o   (ffv_a),
        .first_fail_valid_o (ffvalid_a)
    );

    // Instance B: WIDTH=3, HOLD_CYCLES=1
    logic       start_b = 1'b0;
    logic [2:0] vec_b;
    logic       busy_b, done_b, pass_b, ffvalid_b;
    logic [3:0] err_b;
    logic [2:0] ffv_b;

    reduce_sweep_checker #(.WIDTH(3), .HOLD_CYCLES(1)) u_dut_b (
        .clk                (clk),
        .resetn             (resetn),
        .start_i            (start_b),
        .vec_out_o          (vec_b),
        .dut_and_i          (&vec_b),
        .dut_or_i           (|vec_b),
        .dut_xor_i          (^vec_b),
        .busy_o             (busy_b),
        .done_o             (done_b),
        .pass_o             (pass_b),
        .err_count_o        (err_b),
        .first_fail_vec_o   (ffv_b),
        .first_fail_valid_o (ffvalid_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the start edge until done_a rises; 200 means it never did.
    task automatic run_a(output int n);
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (done_a) break;
        end
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        int n;
        #2;
        check("rst_vec", 32'(vec_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_pass", 32'(pass_a), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_ffvalid", 32'(ffvalid_a), 0);
        check("rst_b_done", 32'(done_b), 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        check("idle_busy", 32'(busy_a), 0);

        // Golden sweep with vector stepping checks
        mode = 2'd0;
        pulse_a();
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (n == 1) check("step_v0", 32'(vec_a), 32'h0);
            if (n == 1) check("step_busy", 32'(busy_a), 1);
            if (n == 4) check("step_v1", 32'(vec_a), 32'h1);
            if (n == 46) check("step_vF", 32'(vec_a), 32'hF);
            if (n == 47) check("step_notdone", 32'(done_a), 0);
            if (done_a) break;
        end
        check("gold_edges", 32'(n), 48);
        check("gold_pass", 32'(pass_a), 1);
        check("gold_err", 32'(err_a), 0);
        check("gold_ffvalid", 32'(ffvalid_a), 0);
        check("gold_busy", 32'(busy_a), 0);

        // xor stuck at 0; restart from DONE
        mode = 2'd1;
        pulse_a();
        check("xor_restart_err", 32'(err_a), 0);
        check("xor_restart_pass", 32'(pass_a), 0);
        run_a(n);
        check("xor_edges", 32'(n), 48);
        check("xor_err", 32'(err_a), 8);
        check("xor_ffv", 32'(ffv_a), 32'h1);
        check("xor_ffvalid", 32'(ffvalid_a), 1);
        check("xor_pass", 32'(pass_a), 0);

        // and wrong only at 4'hF
        mode = 2'd2;
        pulse_a();
        run_a(n);
        check("and_edges", 32'(n), 48);
        check("and_err", 32'(err_a), 1);
        check("and_ffv", 32'(ffv_a), 32'hF);
        check("and_pass", 32'(pass_a), 0);

        // start held high through the sweep
        mode = 2'd1;
        start_a = 1'b1;
        tick();
        run_a(n);
        check("held_edges", 32'(n), 48);
        check("held_err", 32'(err_a), 8);
        tick();
        check("held_restart_done", 32'(done_a), 0);
        check("held_restart_busy", 32'(busy_a), 1);
        check("held_restart_err", 32'(err_a), 0);
        check("held_restart_vec", 32'(vec_a), 0);

        // Async reset while vec_out == 5
        n = 0;
        while (n < 100 && vec_a != 4'h5) begin
            tick();
            n++;
        end
        check("reach_v5", 32'(vec_a), 32'h5);
        #2;
        resetn = 1'b0;
        start_a = 1'b0;
        #1;
        check("arst_vec", 32'(vec_a), 0);
        check("arst_busy", 32'(busy_a), 0);
        check("arst_err", 32'(err_a), 0);
        check("arst_ffvalid", 32'(ffvalid_a), 0);
        check("arst_ffv", 32'(ffv_a), 0);
        #1;
        resetn = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_busy", 32'(busy_a), 0);
        check("post_rst_done", 32'(done_a), 0);
        mode = 2'd0;
        pulse_a();
        run_a(n);
        check("post_rst_edges", 32'(n), 48);
        check("post_rst_pass", 32'(pass_a), 1);
        check("post_rst_err", 32'(err_a), 0);

        // Instance B: WIDTH=3, HOLD_CYCLES=1
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (n == 3) check("b_step_v1", 32'(vec_b), 32'h1);
            if (done_b) break;
        end
        check("b_edges", 32'(n), 16);
        check("b_pass", 32'(pass_b), 1);
        check("b_err", 32'(err_b), 0);
        check("b_ffvalid", 32'(ffvalid_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
